viterbi_frame_seq: RTL and testbench

VITERBI_FRAME_SEQ -- requirements
Module: viterbi_frame_seq

---
 rtl/viterbi_frame_seq_if.sv | 21 ++
 rtl/viterbi_frame_seq.sv | 147 ++++++++++++++
 tb/tb_viterbi_frame_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_frame_seq_if.sv
// rtl/viterbi_frame_seq_if.sv - source, encoder, decoder and output bit streams of the frame sequencer
interface viterbi_frame_seq_if;
  logic src_valid_i;
  logic src_data_i;
  logic src_ready_o;
  logic enc_enable_o;
  logic enc_d_o;
  logic dec_d_i;
  logic out_valid_o;
  logic out_data_o;

  modport slave (
    input  src_valid_i, src_data_i, dec_d_i,
    output src_ready_o, enc_enable_o, enc_d_o, out_valid_o, out_data_o
  );

  modport master (
    output src_valid_i, src_data_i, dec_d_i,
    input  src_ready_o, enc_enable_o, enc_d_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/viterbi_frame_seq.sv
// rtl/viterbi_frame_seq.sv - frame sequencer feeding a K=3 encoder and collecting decoder output bits
module viterbi_frame_seq #(
  parameter int MAX_LEN  = 256,
  parameter int TAIL_LEN = 2,
  parameter int DEC_LAT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [8:0]                frame_len_i,
  input  logic                      abort_i,
  viterbi_frame_seq_if.slave        bus,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  typedef enum logic [2:0] {IDLE, LOAD, TAIL, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [8:0]         len_q;
  logic [8:0]         in_cnt_q;
  logic [8:0]         tail_cnt_q;
  logic [8:0]         out_cnt_q;
  logic               enc_enable_q;
  logic               enc_d_q;
  logic               enc_tag_q;     // current encoder output carries a data bit (not tail/bubble)
  logic [DEC_LAT-1:0] tag_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic src_ready;
  logic xfer;
  logic last_xfer;
  logic len_ok;
  logic out_valid;
  logic kill;

  assign src_ready = (state_q == LOAD) && (in_cnt_q < len_q);
  assign xfer      = src_ready && bus.src_valid_i;
  assign last_xfer = xfer && ((in_cnt_q + 9'd1) == len_q);
  assign len_ok    = (frame_len_i != 9'd0) && (frame_len_i <= 9'(MAX_LEN));
  assign out_valid = tag_q[DEC_LAT-1];
  assign kill      = abort_i && (state_q != IDLE);

  assign bus.src_ready_o  = src_ready;
  assign bus.enc_enable_o = enc_enable_q;
  assign bus.enc_d_o      = enc_d_q;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_data_o   = out_valid & bus.dec_d_i;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

  // Tag pipeline: tag_q[0] lines up with the cycle after the encoder output, so the last stage meets dec_d_i
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[DEC_LAT-2:0], enc_tag_q};
    end
  end

  // Frame FSM with registered encoder drive, status pulses and bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= 9'd0;
      in_cnt_q     <= 9'd0;
      tail_cnt_q   <= 9'd0;
      out_cnt_q    <= 9'd0;
      enc_enable_q <= 1'b0;
      enc_d_q      <= 1'b0;
      enc_tag_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      enc_enable_q <= 1'b0;
      enc_d_q      <= 1'b0;
      enc_tag_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      if (kill) begin
        state_q    <= IDLE;
        in_cnt_q   <= 9'd0;
        tail_cnt_q <= 9'd0;
        out_cnt_q  <= 9'd0;
        busy_q     <= 1'b0;
      end else begin
        if (out_valid && (state_q != IDLE)) begin
          out_cnt_q <= out_cnt_q + 9'd1;
        end
        case (state_q)
          IDLE: begin
            // abort_i in IDLE swallows a simultaneous start without flagging an error
            if (start_i && !abort_i) begin
              if (len_ok) begin
                state_q    <= LOAD;
                len_q      <= frame_len_i;
                in_cnt_q   <= 9'd0;
                tail_cnt_q <= 9'd0;
                out_cnt_q  <= 9'd0;
                busy_q     <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (xfer) begin
              enc_enable_q <= 1'b1;
              enc_d_q      <= bus.src_data_i;
              enc_tag_q    <= 1'b1;
              in_cnt_q     <= in_cnt_q + 9'd1;
              if (last_xfer) begin
                state_q <= (TAIL_LEN > 0) ? TAIL : DRAIN;
              end
            end
          end
          TAIL: begin
            enc_enable_q <= 1'b1;
            tail_cnt_q   <= tail_cnt_q + 9'd1;
            if (tail_cnt_q == 9'(TAIL_LEN - 1)) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (out_cnt_q == len_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_viterbi_frame_seq.sv
// tb/tb_viterbi_frame_seq.sv - scoreboard bench for the viterbi frame sequencer
module tb_viterbi_frame_seq;
  localparam int MAX_LEN  = 256;
  localparam int TAIL_LEN = 2;
  localparam int DEC_LAT  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [8:0] frame_len_i = 9'd0;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  viterbi_frame_seq_if bus();

  viterbi_frame_seq #(.MAX_LEN(MAX_LEN), .TAIL_LEN(TAIL_LEN), .DEC_LAT(DEC_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .frame_len_i(frame_len_i),
    .abort_i(abort_i),
    .bus(bus),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // scoreboard state
  bit    exp_out[$];
  bit    exp_enc[$];
  string pname[$];
  int    pact[$];
  int    pexp[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    tot_out = 0, tot_enc = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0;
  int    cyc = 0;
  bit    mon_e;

  // driver-owned state
  bit fbits[$];
  int base_out, base_enc, base_done, base_err, start_cyc;
  int gaps, pend;
  bit seen;

  // ideal channel: the decoder returns each encoder bit DEC_LAT cycles later
  bit chan[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    chan.push_back(bus.enc_d_o);
    if (chan.size() > DEC_LAT) bus.dec_d_i = chan.pop_front();
    else bus.dec_d_i = 1'b0;
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // monitor: compares DUT streams against the expectation queues, then evaluates posted frame checks
  always @(negedge clk) begin
    if (bus.out_valid_o) begin
      tot_out++;
      check(exp_out.size() != 0, "out_valid_expected", 1, exp_out.size());
      if (exp_out.size() != 0) begin
        mon_e = exp_out.pop_front();
        check(bus.out_data_o == mon_e, "out_data", int'(bus.out_data_o), int'(mon_e));
      end
    end else begin
      check(bus.out_data_o == 1'b0, "out_data_idle", int'(bus.out_data_o), 0);
    end
    if (bus.enc_enable_o) begin
      tot_enc++;
      check(exp_enc.size() != 0, "enc_enable_expected", 1, exp_enc.size());
      if (exp_enc.size() != 0) begin
        mon_e = exp_enc.pop_front();
        check(bus.enc_d_o == mon_e, "enc_d", int'(bus.enc_d_o), int'(mon_e));
      end
    end else begin
      check(bus.enc_d_o == 1'b0, "enc_d_bubble", int'(bus.enc_d_o), 0);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o) err_cnt++;
    while (pname.size() != 0) begin
      check(pact[0] == pexp[0], pname[0], pact[0], pexp[0]);
      void'(pname.pop_front());
      void'(pact.pop_front());
      void'(pexp.pop_front());
    end
  end

  task automatic post(input string name, input int act, input int exp);
    pname.push_back(name);
    pact.push_back(act);
    pexp.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.enc_enable_o) begin
      if (seen) gaps += pend;
      pend = 0;
      seen = 1'b1;
    end else if (seen) begin
      pend++;
    end
  endtask

  task automatic rand_bits(input int n);
    fbits.delete();
    for (int i = 0; i < n; i++) fbits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic begin_frame();
    foreach (fbits[i]) begin
      exp_out.push_back(fbits[i]);
      exp_enc.push_back(fbits[i]);
    end
    for (int i = 0; i < TAIL_LEN; i++) exp_enc.push_back(1'b0);
    base_out = tot_out;
    base_enc = tot_enc;
    base_done = done_cnt;
    base_err = err_cnt;
    gaps = 0;
    pend = 0;
    seen = 1'b0;
    start_i = 1'b1;
    frame_len_i = 9'(fbits.size());
    start_cyc = cyc;
    tick();
    start_i = 1'b0;
    post("busy_after_start", int'(busy_o), 1);
  endtask

  // mode 0: valid always, 1: random valid, 2: valid low for two cycles after the second bit
  task automatic feed(input int mode);
    int idx = 0;
    int budget = 0;
    int gapc = 0;
    bit v;
    bit x;
    while (idx < fbits.size() && budget < 3000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ($urandom_range(0, 3) != 0);
      else begin
        v = !(idx == 2 && gapc < 2);
        if (!v) gapc++;
      end
      bus.src_valid_i = v;
      bus.src_data_i = fbits[idx];
      x = v && bus.src_ready_o;
      tick();
      if (x) idx++;
      budget++;
    end
    bus.src_valid_i = 1'b0;
    bus.src_data_i = 1'b0;
    post("bits_accepted", idx, fbits.size());
  endtask

  task automatic end_frame(input bit chk_lat, input int exp_gaps);
    int budget = 0;
    while (done_cnt == base_done && budget < 3000) begin
      tick();
      budget++;
    end
    tick();
    tick();
    post("done_pulses", done_cnt - base_done, 1);
    if (chk_lat) post("done_latency", done_cyc - start_cyc, DEC_LAT + 7);
    post("out_count", tot_out - base_out, fbits.size());
    post("enc_count", tot_enc - base_enc, fbits.size() + TAIL_LEN);
    post("out_leftover", exp_out.size(), 0);
    post("enc_leftover", exp_enc.size(), 0);
    post("busy_after_done", int'(busy_o), 0);
    post("no_err_in_frame", err_cnt - base_err, 0);
    if (exp_gaps >= 0) post("bubbles", gaps, exp_gaps);
  endtask

  task automatic bad_start(input int len, input bit with_abort);
    base_err = err_cnt;
    base_enc = tot_enc;
    start_i = 1'b1;
    abort_i = with_abort;
    frame_len_i = 9'(len);
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    post("reject_busy", int'(busy_o), 0);
    tick();
    tick();
    post("reject_err_pulses", err_cnt - base_err, with_abort ? 0 : 1);
    post("reject_no_enc", tot_enc - base_enc, 0);
    post("reject_busy_later", int'(busy_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;
    bus.src_valid_i = 1'b0;
    bus.src_data_i = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    post("rst_busy", int'(busy_o), 0);
    post("rst_done", int'(done_o), 0);
    post("rst_err", int'(err_o), 0);
    post("rst_src_ready", int'(bus.src_ready_o), 0);
    post("rst_enc_enable", int'(bus.enc_enable_o), 0);
    post("rst_out_valid", int'(bus.out_valid_o), 0);
    rst = 1'b0;

    // len 4, bits 1011, start on the first cycle after reset release
    fbits.delete();
    fbits.push_back(1'b1); fbits.push_back(1'b0); fbits.push_back(1'b1); fbits.push_back(1'b1);
    begin_frame();
    feed(0);
    end_frame(1'b1, 0);

    // len 3 with a two-cycle source stall mid-frame
    rand_bits(3);
    begin_frame();
    feed(2);
    end_frame(1'b0, 2);

    // rejected requests, and abort beating start in IDLE
    bad_start(0, 1'b0);
    bad_start(257, 1'b0);
    bad_start(5, 1'b1);

    // maximum length frame
    rand_bits(MAX_LEN);
    begin_frame();
    feed(0);
    end_frame(1'b0, 0);

    // random lengths with random source stalls
    for (int f = 0; f < 4; f++) begin
      rand_bits($urandom_range(1, 12));
      begin_frame();
      feed(1);
      end_frame(1'b0, -1);
    end

    // abort in DRAIN after a few decoded bits, then a fresh len 2 frame
    rand_bits(8);
    begin_frame();
    feed(0);
    budget = 0;
    while ((tot_out - base_out) < 3 && budget < 200) begin
      tick();
      budget++;
    end
    post("abort_reached_drain", int'((tot_out - base_out) >= 3), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    exp_out.delete();
    exp_enc.delete();
    post("abort_busy", int'(busy_o), 0);
    post("abort_enc_enable", int'(bus.enc_enable_o), 0);
    post("abort_out_valid", int'(bus.out_valid_o), 0);
    repeat (DEC_LAT + 6) tick();
    post("abort_no_done", done_cnt - base_done, 0);
    rand_bits(2);
    begin_frame();
    feed(0);
    end_frame(1'b0, 0);

    // reset in the middle of LOAD, then a len 5 frame
    rand_bits(6);
    begin_frame();
    bus.src_valid_i = 1'b1;
    bus.src_data_i = fbits[0];
    tick();
    bus.src_data_i = fbits[1];
    tick();
    bus.src_valid_i = 1'b0;
    bus.src_data_i = 1'b0;
    rst = 1'b1;
    tick();
    exp_out.delete();
    exp_enc.delete();
    post("mid_rst_busy", int'(busy_o), 0);
    post("mid_rst_done", int'(done_o), 0);
    post("mid_rst_err", int'(err_o), 0);
    post("mid_rst_src_ready", int'(bus.src_ready_o), 0);
    post("mid_rst_enc_enable", int'(bus.enc_enable_o), 0);
    post("mid_rst_enc_d", int'(bus.enc_d_o), 0);
    post("mid_rst_out_valid", int'(bus.out_valid_o), 0);
    post("mid_rst_out_data", int'(bus.out_data_o), 0);
    rst = 1'b0;
    rand_bits(5);
    begin_frame();
    feed(0);
    end_frame(1'b0, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
